clk_div_multi: RTL and testbench

- Parametrised, multi-channel successor to the board's single fixed divider that drives the 7-segment digit clocks.
- Each channel owns a run-time programmable terminal count and a mode: a square wave (toggle) or a one-cycle strobe (pulse).
- Also provides a per-channel one-cycle tick for synchronous clock-enable use, plus a global enable and reset.
- Sits between the board clock and the counter/display logic; its outputs are meant to be used as enables or slow clocks.

---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clk_div_chan.sv | 50 +++++
 rtl/clk_div_multi.sv | 46 ++++
 tb/tb_clk_div_multi.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the clk_div_multi divider family: channel mode encodings
// and the board-level counter width and default terminal count.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int BOARD_CNT_W       = 26;
  localparam int BOARD_DEFAULT_DIV = 25000000;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counts enabled cycles up to a programmable limit and emits
// a registered square wave or strobe plus a tick; outputs update one cycle after count==limit.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W       = BOARD_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(BOARD_DEFAULT_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             mode,
  output logic             o,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;

  // A write restarts the phase from zero; writes always clear count, so count can
  // never overtake limit and no wrap-around handling is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      limit <= DEFAULT_DIV;
      o     <= 1'b0;
      tick  <= 1'b0;
    end else if (wr) begin
      count <= '0;
      limit <= wr_val;
      o     <= 1'b0;
      tick  <= 1'b0;
    end else if (!en) begin
      tick  <= 1'b0;
    end else if (count == limit) begin
      count <= '0;
      tick  <= 1'b1;
      o     <= (mode == MODE_PULSE) ? 1'b1 : ~o;
    end else begin
      count <= count + 1'b1;
      tick  <= 1'b0;
      if (mode == MODE_PULSE) begin
        o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels sharing en,
// rst and a single terminal-count write bus; out-of-range selects are dropped.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = BOARD_CNT_W,
  parameter int DEFAULT_DIV = BOARD_DEFAULT_DIV,
  parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0] o,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(DEFAULT_DIV);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    localparam logic [SEL_W-1:0] CH_SEL = SEL_W'(ch);

    // Selects with no matching channel decode to no write at all.
    logic wr;
    assign wr = div_we && (div_sel == CH_SEL);

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEF_LIMIT)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .wr     (wr),
      .wr_val (div_val),
      .mode   (mode[ch]),
      .o      (o[ch]),
      .tick   (tick[ch])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised and directed check of clk_div_multi against an arithmetic model of
// each channel's phase (enabled cycles since the last clear, taken modulo limit+1).
module tb_clk_div_multi;

  localparam int NCH   = 3;
  localparam int CW    = 8;
  localparam int DEF   = 3;
  localparam int SW    = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           div_we;
  logic [SW-1:0]  div_sel;
  logic [CW-1:0]  div_val;
  logic [NCH-1:0] mode;
  logic [NCH-1:0] o;
  logic [NCH-1:0] tick;

  int checks = 0;
  int fails  = 0;

  // Model state: n = enabled, unwritten cycles since the last clear.
  int unsigned m_n   [NCH];
  int unsigned m_lim [NCH];
  bit          m_o   [NCH];
  bit          m_t   [NCH];

  clk_div_multi #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DEF),
    .SEL_W       (SW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_we  (div_we),
    .div_sel (div_sel),
    .div_val (div_val),
    .mode    (mode),
    .o       (o),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model with the inputs the DUT is about to sample, clock once,
  // then compare every channel's outputs.
  task automatic cycle();
    logic [NCH-1:0] eo;
    logic [NCH-1:0] et;
    bit             term;
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_n[c] = 0; m_lim[c] = DEF; m_o[c] = 0; m_t[c] = 0;
      end else if (div_we && int'(div_sel) == c) begin
        m_n[c] = 0; m_lim[c] = int'(div_val); m_o[c] = 0; m_t[c] = 0;
      end else if (!en) begin
        m_t[c] = 0;
      end else begin
        term   = (m_n[c] % (m_lim[c] + 1)) == m_lim[c];
        m_n[c] = m_n[c] + 1;
        m_t[c] = term;
        if (mode[c]) m_o[c] = term;
        else if (term) m_o[c] = ~m_o[c];
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      eo[c] = m_o[c];
      et[c] = m_t[c];
    end
    chk("model_o", 32'(o), 32'(eo));
    chk("model_tick", 32'(tick), 32'(et));
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic wr(input int sel, input int val);
    div_we  = 1'b1;
    div_sel = SW'(sel);
    div_val = CW'(val);
    cycle();
    div_we  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; div_we = 1'b0; div_sel = '0; div_val = '0; mode = '0;
    for (int c = 0; c < NCH; c++) begin
      m_n[c] = 0; m_lim[c] = DEF; m_o[c] = 0; m_t[c] = 0;
    end
    cycles(3);
    chk("reset_o", 32'(o), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);

    // Default limit 3: first tick four edges after release, o period 8.
    rst = 1'b0;
    cycles(3);
    chk("pre_first_tick", 32'(tick), 32'h0);
    cycle();
    chk("first_tick", 32'(tick), 32'h7);
    chk("first_toggle", 32'(o), 32'h7);
    cycles(4);
    chk("second_tick", 32'(tick), 32'h7);
    chk("second_toggle", 32'(o), 32'h0);

    // Reprogram ch1 to limit 1 mid-count.
    cycle();
    wr(1, 1);
    chk("reprog_clear", 32'(o), 32'h0);
    cycle();
    chk("reprog_idle", 32'(tick), 32'h0);
    cycle();
    chk("reprog_tick_all", 32'(tick), 32'h7);
    cycles(2);
    chk("reprog_tick_ch1", 32'(tick), 32'h2);
    chk("reprog_o", 32'(o), 32'h5);

    // Pulse mode on ch1 with limit 3.
    mode = 3'b010;
    wr(1, 3);
    cycles(4);
    chk("pulse_o1", 32'(o[1]), 32'h1);
    chk("pulse_tick1", 32'(tick[1]), 32'h1);
    cycle();
    chk("pulse_o1_low", 32'(o[1]), 32'h0);

    // Freeze for 5 cycles, then resume; the model carries the phase.
    cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("freeze_tick", 32'(tick), 32'h0);
    end
    en = 1'b1;
    cycles(10);

    // Limit 0 on ch0 in toggle mode: tick constant, o toggles each cycle.
    mode = 3'b000;
    wr(0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("lim0_tick", 32'(tick[0]), 32'h1);
      chk("lim0_o", 32'(o[0]), 32'((i % 2) == 0));
    end

    // Write during a terminal count: no tick on that channel.
    wr(0, 2);
    chk("wr_at_term_tick", 32'(tick[0]), 32'h0);
    chk("wr_at_term_o", 32'(o[0]), 32'h0);

    // Out-of-range select: nothing changes (model compares every channel).
    wr(3, 5);
    cycles(12);

    // Reset mid-operation.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_o", 32'(o), 32'h0);
    chk("midrst_tick", 32'(tick), 32'h0);
    cycles(4);
    chk("midrst_default_tick", 32'(tick), 32'h7);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      en      = ($urandom_range(0, 9) != 0);
      div_we  = ($urandom_range(0, 24) == 0);
      div_sel = SW'($urandom_range(0, 3));
      div_val = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 20))
                                            : CW'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) mode = NCH'($urandom);
      cycle();
    end
    div_we = 1'b0;
    rst    = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
